// File: rtl/crop_up_display_pkg.sv
// Shared constants and types for the 28x28 image buffer / upscaled replay path.
package crop_pkg;

   localparam int unsigned IMG_W   = 28;
   localparam int unsigned IMG_H   = 28;
   localparam int unsigned SX      = 21;
   localparam int unsigned SY      = 16;
   localparam int unsigned X0      = 27;
   localparam int unsigned Y0      = 17;
   localparam int unsigned H_ACT   = 640;
   localparam int unsigned V_ACT   = 480;
   localparam int unsigned IMG_PIX = IMG_W * IMG_H;

   localparam int unsigned X_END   = X0 + IMG_W * SX - 1;
   localparam int unsigned Y_END   = Y0 + IMG_H * SY - 1;

   localparam int unsigned H_W     = $clog2(H_ACT);
   localparam int unsigned V_W     = $clog2(V_ACT);
   localparam int unsigned ADDR_W  = $clog2(IMG_PIX);
   localparam int unsigned COL_W   = $clog2(IMG_W);
   localparam int unsigned ROW_W   = $clog2(IMG_H);
   localparam int unsigned SUBX_W  = $clog2(SX);
   localparam int unsigned SUBY_W  = $clog2(SY);
   localparam int unsigned DATA_W  = 12;

   typedef logic [7:0] pix_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      VALID   = 2'd2
   } state_e;

   // 8-bit sample replicated into 12-bit grayscale
   function automatic logic [DATA_W-1:0] gray12(input pix_t p);
      return {p, p[7:4]};
   endfunction

endpackage

// File: rtl/crop_up_display_raster.sv
// Display raster position and tile counters; yields window hit and buffer read address
// without any division.
module crop_up_raster
   import crop_pkg::*;
(
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              sof_i,
   input  logic              req_i,
   output logic              in_win_c_o,
   output logic [ADDR_W-1:0] rd_addr_c_o
);

   logic [H_W-1:0]    h_q, h_d, pos_h;
   logic [V_W-1:0]    v_q, v_d, pos_v;
   logic [SUBX_W-1:0] sub_x_q, sub_x_d, sub_x;
   logic [SUBY_W-1:0] sub_y_q, sub_y_d, sub_y;
   logic [COL_W-1:0]  col_q, col_d, col;
   logic [ROW_W-1:0]  row_q, row_d, row;
   logic              in_x, in_y;

   // iSOF relocates the current position to (0,0) before it is emitted
   always_comb begin
      pos_h = sof_i ? '0 : h_q;
      pos_v = sof_i ? '0 : v_q;
      sub_x = sof_i ? '0 : sub_x_q;
      col   = sof_i ? '0 : col_q;
      sub_y = sof_i ? '0 : sub_y_q;
      row   = sof_i ? '0 : row_q;
      in_x  = (pos_h >= H_W'(X0)) && (pos_h <= H_W'(X_END));
      in_y  = (pos_v >= V_W'(Y0)) && (pos_v <= V_W'(Y_END));
   end

   always_comb begin
      h_d     = pos_h;
      v_d     = pos_v;
      sub_x_d = sub_x;
      col_d   = col;
      sub_y_d = sub_y;
      row_d   = row;
      if (req_i) begin
         if (in_x) begin
            if (pos_h == H_W'(X_END)) begin
               sub_x_d = '0;
               col_d   = '0;
            end else if (sub_x == SUBX_W'(SX - 1)) begin
               sub_x_d = '0;
               col_d   = col + COL_W'(1);
            end else begin
               sub_x_d = sub_x + SUBX_W'(1);
            end
         end
         if (pos_h == H_W'(H_ACT - 1)) begin
            h_d = '0;
            v_d = (pos_v == V_W'(V_ACT - 1)) ? '0 : pos_v + V_W'(1);
            // tile rows step once per completed line inside the window
            if (in_y) begin
               if (pos_v == V_W'(Y_END)) begin
                  sub_y_d = '0;
                  row_d   = '0;
               end else if (sub_y == SUBY_W'(SY - 1)) begin
                  sub_y_d = '0;
                  row_d   = row + ROW_W'(1);
               end else begin
                  sub_y_d = sub_y + SUBY_W'(1);
               end
            end
         end else begin
            h_d = pos_h + H_W'(1);
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         h_q     <= '0;
         v_q     <= '0;
         sub_x_q <= '0;
         col_q   <= '0;
         sub_y_q <= '0;
         row_q   <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         sub_x_q <= sub_x_d;
         col_q   <= col_d;
         sub_y_q <= sub_y_d;
         row_q   <= row_d;
      end
   end

   // row*28 + col as shifted adds
   assign in_win_c_o  = in_x && in_y;
   assign rd_addr_c_o = (ADDR_W'(row) << 4) + (ADDR_W'(row) << 3)
                      + (ADDR_W'(row) << 2) + ADDR_W'(col);

endmodule

// File: rtl/crop_up_display.sv
// 28x28 capture buffer replayed as a nearest-neighbour upscaled grayscale raster.
// Optional CROPUP_PINGPONG_EN: two banks, swapped at the next iSOF after an image completes.
module crop_up_display
   import crop_pkg::*;
(
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iBUF_RST,
   input  logic              iPXL_VAL,
   input  pix_t              iPXL,
   input  logic              iSOF,
   input  logic              iREQ,
   output logic              oDVAL,
   output logic [DATA_W-1:0] oDATA,
   output logic              oIMG_DONE,
   output logic              oIMG_VALID
);

`ifdef CROPUP_PINGPONG_EN
   localparam bit KEEP_VALID = 1'b1;
`else
   localparam bit KEEP_VALID = 1'b0;
`endif

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                wr_c, last_c, in_win_c, disp_en_c;
   logic [ADDR_W-1:0]   rd_addr_c;
   pix_t                rd_pix_c;
   logic                dval_d, done_d, valid_d;
   logic [DATA_W-1:0]   data_d;

   crop_up_raster u_raster (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .sof_i       (iSOF),
      .req_i       (iREQ),
      .in_win_c_o  (in_win_c),
      .rd_addr_c_o (rd_addr_c)
   );

   // buffer clear wins over a coincident write
   assign wr_c   = iPXL_VAL && !iBUF_RST;
   assign last_c = wr_c && (wr_ptr_q == ADDR_W'(IMG_PIX - 1));

`ifdef CROPUP_PINGPONG_EN
   pix_t mem_q [2][IMG_PIX];
   logic front_q, front_d, swap_pend_q, swap_pend_d, front_ok_q, front_ok_d;

   always_ff @(posedge iCLK) begin
      if (wr_c) mem_q[~front_q][wr_ptr_q] <= iPXL;
   end

   always_comb begin
      front_d     = front_q;
      swap_pend_d = swap_pend_q;
      front_ok_d  = front_ok_q;
      if (iBUF_RST) begin
         swap_pend_d = 1'b0;
         front_ok_d  = 1'b0;
      end else begin
         if (iSOF && swap_pend_q) begin
            front_d     = ~front_q;
            swap_pend_d = 1'b0;
            front_ok_d  = 1'b1;
         end
         if (last_c) swap_pend_d = 1'b1;
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         front_q     <= 1'b0;
         swap_pend_q <= 1'b0;
         front_ok_q  <= 1'b0;
      end else begin
         front_q     <= front_d;
         swap_pend_q <= swap_pend_d;
         front_ok_q  <= front_ok_d;
      end
   end

   assign rd_pix_c  = mem_q[front_q][rd_addr_c];
   assign disp_en_c = front_ok_q && (state_q != EMPTY);
`else
   pix_t mem_q [IMG_PIX];

   // combinational read sees the pre-write contents on a same-address collision
   always_ff @(posedge iCLK) begin
      if (wr_c) mem_q[wr_ptr_q] <= iPXL;
   end

   assign rd_pix_c  = mem_q[rd_addr_c];
   assign disp_en_c = (state_q != EMPTY);
`endif

   // state and output registers
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q    <= EMPTY;
         wr_ptr_q   <= '0;
         oDVAL      <= 1'b0;
         oDATA      <= '0;
         oIMG_DONE  <= 1'b0;
         oIMG_VALID <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         oDVAL      <= dval_d;
         oDATA      <= data_d;
         oIMG_DONE  <= done_d;
         oIMG_VALID <= valid_d;
      end
   end

   // next state and write pointer
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      if (iBUF_RST) begin
         state_d  = EMPTY;
         wr_ptr_d = '0;
      end else if (wr_c) begin
         wr_ptr_d = last_c ? '0 : wr_ptr_q + ADDR_W'(1);
         if (last_c) begin
            state_d = VALID;
         end else if (!(KEEP_VALID && (state_q == VALID))) begin
            state_d = FILLING;
         end
      end
   end

   // output next values
   always_comb begin
      dval_d  = iREQ;
      data_d  = '0;
      done_d  = last_c;
      valid_d = (state_d == VALID);
      if (iREQ && in_win_c && disp_en_c) data_d = gray12(rd_pix_c);
   end

endmodule
